// File: rtl/dmem_arb.sv
// Data-memory arbiter: one shared synchronous-read memory port, serving the CPU
// memory stage and a DMA/loader master. The CPU normally wins. A DMA request
// that has waited STARVE_LIMIT cycles wins once. The DMA may hold a locked
// burst for up to LOCK_MAX back-to-back grants. A burst that reaches LOCK_MAX
// is followed by one guaranteed CPU slot.
module dmem_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_adr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic        MemWrite,
    output logic [31:0] DataAdr,
    output logic [31:0] WriteData,
    input  logic [31:0] mem_rdata,
    output logic [15:0] stall_cnt
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [WW-1:0] SLIM = WW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LMAX = LW'(LOCK_MAX);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CPU  = 2'd1;
    localparam logic [1:0] DMA  = 2'd2;
    localparam logic [1:0] LOCK = 2'd3;

    // r_state is LOCK while a burst is open, otherwise the previous owner
    logic [1:0]    r_state;
    logic [WW-1:0] r_wcnt;
    logic [LW-1:0] r_lcnt;
    logic          r_force;
    logic          r_cpu_rvalid;
    logic          r_dma_rvalid;
    logic [15:0]   r_stall_cnt;

    logic [1:0]    w_owner;
    logic          w_cpu_gnt;
    logic          w_dma_gnt;
    logic          w_lock_act;
    logic          w_lock_grant;
    logic [LW-1:0] w_lcnt_inc;
    logic          w_lock_full;
    logic          w_stall;

    // mem_rdata is routed outside this block; the arbiter only tags ownership
    logic          w_unused_rdata;
    assign w_unused_rdata = ^mem_rdata;

    // A burst only continues while the DMA keeps asking for it
    assign w_lock_act   = (r_state == LOCK) & dma_req & dma_lock;
    assign w_lcnt_inc   = r_lcnt + 1'b1;
    assign w_lock_grant = w_dma_gnt & dma_lock;
    assign w_lock_full  = w_lock_grant & (w_lcnt_inc == LMAX);

    // Owner of this cycle's access, decided purely from state and live requests
    always_comb begin
        w_owner = IDLE;
        if (!reset)
            w_owner = IDLE;
        else if (w_lock_act)
            w_owner = LOCK;
        else if (r_force && cpu_req)
            w_owner = CPU;
        else if (cpu_req && dma_req)
            w_owner = (r_wcnt == SLIM) ? DMA : CPU;
        else if (cpu_req)
            w_owner = CPU;
        else if (dma_req)
            w_owner = DMA;
    end

    assign w_cpu_gnt = (w_owner == CPU);
    assign w_dma_gnt = (w_owner == DMA) | (w_owner == LOCK);
    assign w_stall   = reset & cpu_req & ~w_cpu_gnt;

    assign cpu_stall  = w_stall;
    assign dma_gnt    = w_dma_gnt;
    assign MemWrite   = (w_cpu_gnt & cpu_we) | (w_dma_gnt & dma_we);
    assign DataAdr    = w_dma_gnt ? dma_adr : cpu_adr;
    assign WriteData  = w_dma_gnt ? dma_wdata : cpu_wdata;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign stall_cnt  = r_stall_cnt;

    // Ownership state, burst length and the one-shot CPU slot after a full burst
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_lcnt  <= '0;
            r_force <= 1'b0;
        end else begin
            r_force <= w_lock_full;
            if (w_lock_grant && !w_lock_full) begin
                r_state <= LOCK;
                r_lcnt  <= w_lcnt_inc;
            end else begin
                r_state <= (w_owner == LOCK) ? DMA : w_owner;
                r_lcnt  <= '0;
            end
        end
    end

    // DMA starvation counter: counts lost cycles, saturates, clears on a grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_wcnt <= '0;
        else if (w_dma_gnt)
            r_wcnt <= '0;
        else if (dma_req && (r_wcnt != SLIM))
            r_wcnt <= r_wcnt + 1'b1;
    end

    // Read-return tags: one cycle after a granted read, never for writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~cpu_we;
            r_dma_rvalid <= w_dma_gnt & ~dma_we;
        end
    end

    // Saturating count of CPU stall cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: a directed vector table, hand sequences for lock, reset
// and saturation corners, and random traffic against a rule-level model.
module tb_dmem_arb;

    localparam int SL = 4;
    localparam int LM = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [31:0] cpu_adr, cpu_wdata, dma_adr, dma_wdata, mem_rdata;
    logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, MemWrite;
    logic [31:0] DataAdr, WriteData;
    logic [15:0] stall_cnt;

    // second instance with a very long burst limit, for stall_cnt saturation
    logic        s_reset, s_cpu_req, s_dma_req, s_dma_lock;
    logic        s_cpu_stall, s_cpu_rvalid, s_dma_gnt, s_dma_rvalid, s_MemWrite;
    logic [31:0] s_DataAdr, s_WriteData;
    logic [15:0] s_stall_cnt;

    dmem_arb #(.STARVE_LIMIT(SL), .LOCK_MAX(LM)) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    dmem_arb #(.STARVE_LIMIT(SL), .LOCK_MAX(1 << 20)) u_sat (
        .clk(clk), .reset(s_reset),
        .cpu_req(s_cpu_req), .cpu_we(1'b0), .cpu_adr(32'h0), .cpu_wdata(32'h0),
        .cpu_stall(s_cpu_stall), .cpu_rvalid(s_cpu_rvalid),
        .dma_req(s_dma_req), .dma_we(1'b1), .dma_adr(32'h10), .dma_wdata(32'h0),
        .dma_lock(s_dma_lock), .dma_gnt(s_dma_gnt), .dma_rvalid(s_dma_rvalid),
        .MemWrite(s_MemWrite), .DataAdr(s_DataAdr), .WriteData(s_WriteData),
        .mem_rdata(32'h0), .stall_cnt(s_stall_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        creq, cwe;
        logic [31:0] cadr, cwd;
        logic        dreq, dwe;
        logic [31:0] dadr, dwd;
        logic        dlock;
        logic        e_stall, e_dgnt, e_mw;
        logic [31:0] e_adr, e_wd;
        logic        e_crv, e_drv;
        logic [15:0] e_scnt;
    } vec_t;

    vec_t tv[12];

    // ---------------- reference model (arbitration rules as plain ints) ----
    int m_wait, m_lcnt, m_scnt, m_last_own;
    bit m_locked, m_force, m_crv, m_drv;

    task automatic model_reset();
        m_wait = 0; m_lcnt = 0; m_scnt = 0; m_last_own = 0;
        m_locked = 0; m_force = 0; m_crv = 0; m_drv = 0;
    endtask

    // owner: 0 none, 1 CPU, 2 DMA; compares live outputs then advances a cycle
    task automatic model_check_step();
        int  own;
        bit  st;
        logic exp_mw;
        own = 0;
        if (m_locked && dma_req && dma_lock)  own = 2;
        else if (m_force && cpu_req)          own = 1;
        else if (cpu_req && dma_req)          own = (m_wait == SL) ? 2 : 1;
        else if (cpu_req)                     own = 1;
        else if (dma_req)                     own = 2;
        st = cpu_req && (own != 1);
        exp_mw = (own == 1) ? cpu_we : (own == 2) ? dma_we : 1'b0;
        chk("rnd_cpu_stall", cpu_stall, st);
        chk("rnd_dma_gnt", dma_gnt, own == 2);
        chk("rnd_memwrite", MemWrite, exp_mw);
        if (own == 1) begin
            chk("rnd_adr_cpu", DataAdr, cpu_adr);
            chk("rnd_wd_cpu", WriteData, cpu_wdata);
        end else if (own == 2) begin
            chk("rnd_adr_dma", DataAdr, dma_adr);
            chk("rnd_wd_dma", WriteData, dma_wdata);
        end
        chk("rnd_cpu_rvalid", cpu_rvalid, m_crv);
        chk("rnd_dma_rvalid", dma_rvalid, m_drv);
        chk("rnd_stall_cnt", stall_cnt, m_scnt);
        // advance
        if (st && m_scnt < 65535) m_scnt++;
        m_crv = (own == 1) && !cpu_we;
        m_drv = (own == 2) && !dma_we;
        if (own == 2) m_wait = 0;
        else if (dma_req && m_wait < SL) m_wait++;
        m_force = 0;
        if (own == 2 && dma_lock) begin
            m_lcnt++;
            if (m_lcnt == LM) begin
                m_locked = 0; m_lcnt = 0; m_force = 1;
            end else
                m_locked = 1;
        end else begin
            m_locked = 0; m_lcnt = 0;
        end
        m_last_own = own;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_adr = 0; dma_wdata = 0; dma_lock = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // watchdog: the run is fixed-length, this only guards against a stuck sim
    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        mem_rdata = 32'h0;
        s_reset = 0; s_cpu_req = 0; s_dma_req = 0; s_dma_lock = 0;
        reset = 0;
        idle_inputs();

        //                    creq cwe cadr cwd  dreq dwe dadr dwd lk  stl dg mw adr  wd crv drv scnt
        tv[0]  = '{1, 1, 100, 25, 0, 0, 0,   0, 0,  0, 0, 1, 100, 25, 0, 0, 0};
        tv[1]  = '{0, 0, 0,   0,  1, 0, 96,  0, 0,  0, 1, 0, 96,  0,  0, 0, 0};
        tv[2]  = '{0, 0, 0,   0,  0, 0, 0,   0, 0,  0, 0, 0, 0,   0,  0, 1, 0};
        tv[3]  = '{1, 0, 8,   0,  0, 0, 0,   0, 0,  0, 0, 0, 8,   0,  0, 0, 0};
        tv[4]  = '{0, 0, 0,   0,  0, 0, 0,   0, 0,  0, 0, 0, 0,   0,  1, 0, 0};
        tv[5]  = '{0, 0, 0,   0,  0, 0, 0,   0, 0,  0, 0, 0, 0,   0,  0, 0, 0};
        tv[6]  = '{1, 1, 4,   1,  1, 1, 200, 2, 0,  0, 0, 1, 4,   1,  0, 0, 0};
        tv[7]  = '{1, 1, 4,   1,  1, 1, 200, 2, 0,  0, 0, 1, 4,   1,  0, 0, 0};
        tv[8]  = '{1, 1, 4,   1,  1, 1, 200, 2, 0,  0, 0, 1, 4,   1,  0, 0, 0};
        tv[9]  = '{1, 1, 4,   1,  1, 1, 200, 2, 0,  0, 0, 1, 4,   1,  0, 0, 0};
        tv[10] = '{1, 1, 4,   1,  1, 1, 200, 2, 0,  1, 1, 1, 200, 2,  0, 0, 0};
        tv[11] = '{1, 1, 4,   1,  0, 0, 0,   0, 0,  0, 0, 1, 4,   1,  0, 0, 1};

        // reset holds everything quiet even with requests present
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 1; dma_req = 1; dma_we = 1;
        #2;
        chk("rst_cpu_stall", cpu_stall, 0);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_memwrite", MemWrite, 0);
        chk("rst_rvalids", {cpu_rvalid, dma_rvalid}, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b1;

        // directed vector table, first row in the first cycle after release
        for (int i = 0; i < 12; i++) begin
            cpu_req = tv[i].creq; cpu_we = tv[i].cwe; cpu_adr = tv[i].cadr; cpu_wdata = tv[i].cwd;
            dma_req = tv[i].dreq; dma_we = tv[i].dwe; dma_adr = tv[i].dadr; dma_wdata = tv[i].dwd;
            dma_lock = tv[i].dlock;
            @(negedge clk);
            chk($sformatf("tv%0d_cpu_stall", i), cpu_stall, tv[i].e_stall);
            chk($sformatf("tv%0d_dma_gnt", i), dma_gnt, tv[i].e_dgnt);
            chk($sformatf("tv%0d_memwrite", i), MemWrite, tv[i].e_mw);
            if (tv[i].e_dgnt || (tv[i].creq && !tv[i].e_stall)) begin
                chk($sformatf("tv%0d_adr", i), DataAdr, tv[i].e_adr);
                chk($sformatf("tv%0d_wdata", i), WriteData, tv[i].e_wd);
            end
            chk($sformatf("tv%0d_cpu_rvalid", i), cpu_rvalid, tv[i].e_crv);
            chk($sformatf("tv%0d_dma_rvalid", i), dma_rvalid, tv[i].e_drv);
            chk($sformatf("tv%0d_stall_cnt", i), stall_cnt, tv[i].e_scnt);
            @(posedge clk); #1;
        end

        // lock burst under contention: 4 CPU, 8 locked DMA, forced CPU + 3 CPU, DMA again
        do_reset();
        cpu_req = 1; cpu_adr = 32'h10; dma_req = 1; dma_we = 1; dma_adr = 32'h20; dma_lock = 1;
        for (int k = 0; k < 24; k++) begin
            bit exp_d;
            exp_d = (k >= 4 && k < 12) || (k >= 16);
            @(negedge clk);
            chk($sformatf("lock_c%0d_dma_gnt", k), dma_gnt, exp_d);
            chk($sformatf("lock_c%0d_cpu_stall", k), cpu_stall, exp_d);
            @(posedge clk); #1;
        end

        // reset in the middle of a locked read burst with a read return pending
        do_reset();
        dma_req = 1; dma_we = 0; dma_adr = 32'd96; dma_lock = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mid_lock_gnt%0d", k), dma_gnt, 1);
            @(posedge clk); #1;
        end
        chk("mid_lock_rvalid_before_rst", dma_rvalid, 1);
        cpu_req = 1;
        #1 reset = 1'b0;
        #1;
        chk("mid_lock_rst_dma_gnt", dma_gnt, 0);
        chk("mid_lock_rst_dma_rvalid", dma_rvalid, 0);
        chk("mid_lock_rst_cpu_stall", cpu_stall, 0);
        chk("mid_lock_rst_memwrite", MemWrite, 0);
        @(posedge clk); @(posedge clk); #1;
        dma_req = 0; dma_lock = 0; cpu_req = 1; cpu_we = 0; cpu_adr = 32'h40;
        reset = 1'b1;
        #1;
        chk("post_rst_cpu_stall", cpu_stall, 0);
        chk("post_rst_adr", DataAdr, 32'h40);
        chk("post_rst_dma_gnt", dma_gnt, 0);
        chk("post_rst_no_stale_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        @(posedge clk); #1;
        chk("post_rst_cpu_rvalid", cpu_rvalid, 1);
        chk("post_rst_dma_rvalid", dma_rvalid, 0);

        // random traffic against the model; requesters hold until granted
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            if (!(cpu_req && m_last_own != 1)) begin
                cpu_req = ($urandom_range(0, 9) < 7);
                cpu_we = 1'($urandom_range(0, 1));
                cpu_adr = $urandom; cpu_wdata = $urandom;
            end
            if (!(dma_req && m_last_own != 2)) begin
                dma_req = ($urandom_range(0, 9) < 7);
                dma_we = 1'($urandom_range(0, 1));
                dma_adr = $urandom; dma_wdata = $urandom;
            end
            dma_lock = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            model_check_step();
            @(posedge clk); #1;
        end

        // stall counter saturation: CPU starves behind a never-ending lock
        s_cpu_req = 1; s_dma_req = 1; s_dma_lock = 1;
        s_reset = 1'b1;
        for (int k = 0; k <= 70000; k++) begin
            @(negedge clk);
            if (k == 4)     chk("sat_dma_takes_lock", s_dma_gnt, 1);
            if (k == 65538) chk("sat_stall_cnt_fffe", s_stall_cnt, 16'hFFFE);
            if (k == 65539) chk("sat_stall_cnt_ffff", s_stall_cnt, 16'hFFFF);
            if (k == 70000) begin
                chk("sat_stall_cnt_hold", s_stall_cnt, 16'hFFFF);
                chk("sat_lock_held", s_dma_gnt, 1);
                chk("sat_cpu_stall", s_cpu_stall, 1);
            end
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
